// File: rtl/shift_pkg.sv
// Shared shift-operation codes and widths, also used by the ALU decoder.
// The bit-reverse helper lets the left shift reuse the right-shifting barrel.
package shift_pkg;
    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    localparam logic [1:0] SHIFT_SRL  = 2'b00;
    localparam logic [1:0] SHIFT_SLL  = 2'b01;
    localparam logic [1:0] SHIFT_SRA  = 2'b10;
    localparam logic [1:0] SHIFT_PASS = 2'b11;

    function automatic logic [XLEN-1:0] bit_reverse(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] rev;
        rev = '0;
        for (int i = 0; i < XLEN; i++) begin
            rev[i] = v[XLEN-1-i];
        end
        return rev;
    endfunction
endpackage

// File: rtl/shift_stage.sv
// One level of the logarithmic barrel: a right shift by D, filling the
// vacated high bits with fill, or a straight pass when en is low.
module shift_stage
    import shift_pkg::*;
#(
    parameter int D = 1
) (
    input  logic [XLEN-1:0] in,
    input  logic            en,
    input  logic            fill,
    output logic [XLEN-1:0] out
);

    always_comb begin
        out = in;
        if (en) begin
            out = {{D{fill}}, in[XLEN-1:D]};
        end
    end

endmodule

// File: rtl/barrel_shifter.sv
// Registered 32-bit SRL/SLL/SRA/pass shifter for the RV32I ALU.
// Combinational 5-level barrel feeding a one-cycle output register.
module barrel_shifter
    import shift_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [XLEN-1:0]    a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         shift_type,
    output logic [XLEN-1:0]    r,
    output logic               out_valid
);

    logic               is_left;
    logic               fill;
    logic [SHAMT_W-1:0] eff_shamt;
    logic [XLEN-1:0]    result;
    logic [XLEN-1:0]    stage_data [0:SHAMT_W];

    always_comb begin
        is_left   = (shift_type == SHIFT_SLL);
        fill      = (shift_type == SHIFT_SRA) && a[XLEN-1];
        eff_shamt = (shift_type == SHIFT_PASS) ? '0 : shamt;
    end

    // Left shifts run through the same right-shifting barrel on reversed data.
    assign stage_data[0] = is_left ? bit_reverse(a) : a;

    genvar k;
    generate
        for (k = 0; k < SHAMT_W; k++) begin : g_stage
            shift_stage #(.D(1 << k)) u_stage (
                .in   (stage_data[k]),
                .en   (eff_shamt[k]),
                .fill (fill),
                .out  (stage_data[k+1])
            );
        end
    endgenerate

    assign result = is_left ? bit_reverse(stage_data[SHAMT_W]) : stage_data[SHAMT_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r         <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                r <= result;
            end
        end
    end

endmodule

// File: tb/tb_barrel_shifter.sv
// Directed and randomized checks of barrel_shifter against an arithmetic
// reference using the language's own shift operators.
module tb_barrel_shifter;
    import shift_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  shift_type;
    logic [31:0] r;
    logic        out_valid;

    int n_assert;
    int n_fail;
    logic [31:0] exp_r;

    barrel_shifter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .a          (a),
        .shamt      (shamt),
        .shift_type (shift_type),
        .r          (r),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(input logic [31:0] va,
                                              input logic [4:0] vs,
                                              input logic [1:0] vt);
        logic [31:0] res;
        case (vt)
            2'b00:   res = va >> vs;
            2'b01:   res = va << vs;
            2'b10:   res = $signed(va) >>> vs;
            default: res = va;
        endcase
        return res;
    endfunction

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, expv);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, expv);
        end
    endtask

    // Drive one cycle at the falling edge, check just after the rising edge.
    task automatic step(input logic v, input logic [31:0] va, input logic [4:0] vs,
                        input logic [1:0] vt, input logic [31:0] lit, input bit use_lit,
                        input string tag);
        @(negedge clk);
        in_valid   = v;
        a          = va;
        shamt      = vs;
        shift_type = vt;
        @(posedge clk);
        #1;
        if (v) exp_r = use_lit ? lit : ref_shift(va, vs, vt);
        check32(tag, r, exp_r);
        check1({tag, "_valid"}, out_valid, v);
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        exp_r      = '0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        shamt      = '0;
        shift_type = '0;
        #12;
        check32("reset_r", r, 32'h0);
        check1("reset_valid", out_valid, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        step(1, 32'h8000_0000, 5'd4,  SHIFT_SRL, 32'h0800_0000, 1, "srl_4");
        step(1, 32'h8000_0000, 5'd31, SHIFT_SRL, 32'h0000_0001, 1, "srl_31");
        step(1, 32'h8000_0000, 5'd4,  SHIFT_SRA, 32'hF800_0000, 1, "sra_neg");
        step(1, 32'h7FFF_FFF0, 5'd4,  SHIFT_SRA, 32'h07FF_FFFF, 1, "sra_pos");
        step(1, 32'hFFFF_FFFF, 5'd31, SHIFT_SRA, 32'hFFFF_FFFF, 1, "sra_ones");
        step(1, 32'h0000_0001, 5'd31, SHIFT_SLL, 32'h8000_0000, 1, "sll_31");
        step(1, 32'h1234_5678, 5'd8,  SHIFT_SLL, 32'h3456_7800, 1, "sll_8");
        for (int t = 0; t < 4; t++) begin
            step(1, 32'hDEAD_BEEF, 5'd0, t[1:0], 32'hDEAD_BEEF, 1, "shamt0");
        end
        step(1, 32'hDEAD_BEEF, 5'd7, SHIFT_PASS, 32'hDEAD_BEEF, 1, "pass_7");
        step(1, 32'hF0F0_0000, 5'd3, SHIFT_SRL, 32'h1E1E_0000, 1, "pre_hold");
        step(0, 32'h1234_5678, 5'd1, SHIFT_SLL, 32'h0, 0, "hold");

        // Asynchronous reset in the middle of a cycle, with a result in flight.
        @(negedge clk);
        in_valid   = 1'b1;
        a          = 32'hCAFE_F00D;
        shamt      = 5'd2;
        shift_type = SHIFT_SLL;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_r = '0;
        check32("async_reset_r", r, 32'h0);
        check1("async_reset_valid", out_valid, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        for (int i = 0; i < 10000; i++) begin
            logic        v;
            logic [31:0] ra;
            logic [4:0]  rs;
            logic [1:0]  rt;
            v  = ($urandom_range(0, 15) != 0);
            ra = $urandom;
            rs = 5'($urandom_range(0, 31));
            rt = 2'($urandom_range(0, 3));
            step(v, ra, rs, rt, 32'h0, 0, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
